// File: rtl/wb_arbiter2.sv
// Two-master, one-slave pipelined Wishbone arbiter with per-cyc round-robin grant.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck bus cycle after TIMEOUT cycles.
module wb_arbiter2 #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int SELW    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [SELW-1:0] i_m0_sel,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  output logic            o_m0_stall,
  output logic [DW-1:0]   o_m0_data,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [SELW-1:0] i_m1_sel,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic            o_m1_stall,
  output logic [DW-1:0]   o_m1_data,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [SELW-1:0] o_s_sel,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  input  logic            i_s_stall,
  input  logic [DW-1:0]   i_s_data,
  output logic [1:0]      o_grant
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
`ifdef WB_ARB_TIMEOUT_EN
    , ABORT
`endif
  } state_t;

  state_t state_reg, state_next;
  logic   last_reg, last_next;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt_reg, cnt_next;
  logic       owner_cyc;
  logic       timeout_hit;

  always_comb begin
    owner_cyc = 1'b0;
    if (state_reg == GNT0) owner_cyc = i_m0_cyc;
    if (state_reg == GNT1) owner_cyc = i_m1_cyc;
    timeout_hit = owner_cyc && !i_s_ack && !i_s_err && (cnt_reg == 8'(TIMEOUT - 1));
    cnt_next = cnt_reg;
    if (state_next != state_reg || i_s_ack || i_s_err) cnt_next = 8'd0;
    else if (owner_cyc) cnt_next = cnt_reg + 8'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) cnt_reg <= 8'd0;
    else          cnt_reg <= cnt_next;
  end
`endif

  // Owner keeps the bus until it drops cyc; on a tie the master not granted last wins.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_reg)) begin
          state_next = GNT0;
          last_next  = 1'b0;
        end else if (i_m1_cyc) begin
          state_next = GNT1;
          last_next  = 1'b1;
        end
      end
      GNT0: begin
        if (!i_m0_cyc) begin
          state_next = i_m1_cyc ? GNT1 : IDLE;
          if (i_m1_cyc) last_next = 1'b1;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) state_next = ABORT;
`endif
      end
      GNT1: begin
        if (!i_m1_cyc) begin
          state_next = i_m0_cyc ? GNT0 : IDLE;
          if (i_m0_cyc) last_next = 1'b0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit) state_next = ABORT;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_sel    = '0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_stall = 1'b1;
    o_m0_data  = '0;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_stall = 1'b1;
    o_m1_data  = '0;
    o_grant    = 2'b00;
    case (state_reg)
      GNT0: begin
        o_s_cyc    = i_m0_cyc;
        o_s_stb    = i_m0_stb;
        o_s_we     = i_m0_we;
        o_s_sel    = i_m0_sel;
        o_s_addr   = i_m0_addr;
        o_s_data   = i_m0_data;
        o_m0_ack   = i_s_ack;
        o_m0_err   = i_s_err;
        o_m0_stall = i_s_stall;
        o_m0_data  = i_s_data;
        o_m1_data  = i_s_data;
        o_grant    = 2'b01;
      end
      GNT1: begin
        o_s_cyc    = i_m1_cyc;
        o_s_stb    = i_m1_stb;
        o_s_we     = i_m1_we;
        o_s_sel    = i_m1_sel;
        o_s_addr   = i_m1_addr;
        o_s_data   = i_m1_data;
        o_m1_ack   = i_s_ack;
        o_m1_err   = i_s_err;
        o_m1_stall = i_s_stall;
        o_m0_data  = i_s_data;
        o_m1_data  = i_s_data;
        o_grant    = 2'b10;
      end
`ifdef WB_ARB_TIMEOUT_EN
      // last_reg still names the master whose cycle is being aborted.
      ABORT: begin
        o_m0_err = !last_reg;
        o_m1_err = last_reg;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench for wb_arbiter2: vector table for grant/routing, scoreboarded pipelined burst,
// isolation, asynchronous reset and (with WB_ARB_TIMEOUT_EN) watchdog abort sequences.
module tb_wb_arbiter2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SELW = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic i_clk, i_reset;
  logic i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we;
  logic [SELW-1:0] i_m0_sel, i_m1_sel, o_s_sel;
  logic [AW-1:0] i_m0_addr, i_m1_addr, o_s_addr;
  logic [DW-1:0] i_m0_data, i_m1_data, o_m0_data, o_m1_data, o_s_data, i_s_data;
  logic o_m0_ack, o_m0_err, o_m0_stall, o_m1_ack, o_m1_err, o_m1_stall;
  logic o_s_cyc, o_s_stb, o_s_we, i_s_ack, i_s_err, i_s_stall;
  logic [1:0] o_grant;

  wb_arbiter2 #(.AW(AW), .DW(DW), .SELW(SELW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we), .i_m0_sel(i_m0_sel),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_stall(o_m0_stall), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we), .i_m1_sel(i_m1_sel),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_stall(o_m1_stall), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .i_s_ack(i_s_ack), .i_s_err(i_s_err), .i_s_stall(i_s_stall), .i_s_data(i_s_data),
    .o_grant(o_grant)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // in = {rst, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack, s_stall}
  // flg = {s_cyc, m0_stall, m1_stall, m0_ack, m1_ack}
  typedef struct {
    logic [6:0] in;
    logic [1:0] grant;
    logic [4:0] flg;
    logic [7:0] addr;
  } vec_t;

  vec_t tbl[$];
  logic [DW-1:0] sb[$];
  int total, passed;
  int issued, accepts, acks;
  logic acc_prev, acc_now, issue_now, stall_done, m0_ok;
  logic [AW-1:0] acc_addr, acc_addr_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_none;
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0; i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    i_s_ack = 1'b0; i_s_err = 1'b0; i_s_stall = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(o_grant), 32'h0);
    chk({tag, "_s_cyc"}, 32'({o_s_cyc, o_s_stb, o_s_we}), 32'h0);
    chk({tag, "_s_addr"}, 32'(o_s_addr), 32'h0);
    chk({tag, "_s_data"}, o_s_data, 32'h0);
    chk({tag, "_s_sel"}, 32'(o_s_sel), 32'h0);
    chk({tag, "_m_resp"}, 32'({o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack, o_m0_err, o_m1_err}),
        32'b110000);
  endtask

  initial begin
    total = 0; passed = 0;
    i_reset = 1'b0;
    drive_none();
    i_m0_we = 1'b1; i_m0_sel = 4'hF; i_m0_addr = 30'h10; i_m0_data = 32'hDEADBEEF;
    i_m1_we = 1'b0; i_m1_sel = 4'h3; i_m1_addr = 30'h20; i_m1_data = 32'h12345678;
    i_s_data = 32'h0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_vals("por");
    i_reset = 1'b1;
    step();

    tbl.push_back(vec_t'{7'b0000000, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0110000, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0110010, 2'b01, 5'b10110, 8'h10});
    tbl.push_back(vec_t'{7'b0000000, 2'b01, 5'b00100, 8'h10});
    tbl.push_back(vec_t'{7'b0000000, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0111100, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0111110, 2'b10, 5'b11001, 8'h20});
    tbl.push_back(vec_t'{7'b0110000, 2'b10, 5'b01000, 8'h20});
    tbl.push_back(vec_t'{7'b0110001, 2'b01, 5'b11100, 8'h10});
    tbl.push_back(vec_t'{7'b1000000, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0111100, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0111110, 2'b01, 5'b10110, 8'h10});
    tbl.push_back(vec_t'{7'b0001100, 2'b01, 5'b00100, 8'h10});
    tbl.push_back(vec_t'{7'b0001110, 2'b10, 5'b11001, 8'h20});
    tbl.push_back(vec_t'{7'b0000000, 2'b10, 5'b01000, 8'h20});
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(vec_t'{7'b0111100, 2'b00, 5'b01100, 8'h00});
      tbl.push_back(vec_t'{7'b0111100, 2'b01, 5'b10100, 8'h10});
      tbl.push_back(vec_t'{7'b0001100, 2'b01, 5'b00100, 8'h10});
      tbl.push_back(vec_t'{7'b0001100, 2'b10, 5'b11000, 8'h20});
      tbl.push_back(vec_t'{7'b0000000, 2'b10, 5'b01000, 8'h20});
    end
    tbl.push_back(vec_t'{7'b0111100, 2'b00, 5'b01100, 8'h00});
    tbl.push_back(vec_t'{7'b0111100, 2'b01, 5'b10100, 8'h10});
    tbl.push_back(vec_t'{7'b0000000, 2'b01, 5'b00100, 8'h10});
    tbl.push_back(vec_t'{7'b0000000, 2'b00, 5'b01100, 8'h00});

    foreach (tbl[i]) begin
      i_reset = ~tbl[i].in[6];
      i_m0_cyc = tbl[i].in[5]; i_m0_stb = tbl[i].in[4];
      i_m1_cyc = tbl[i].in[3]; i_m1_stb = tbl[i].in[2];
      i_s_ack = tbl[i].in[1]; i_s_stall = tbl[i].in[0];
      #1;
      chk($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d_flags", i),
          32'({o_s_cyc, o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack}), 32'(tbl[i].flg));
      chk($sformatf("vec%0d_addr", i), 32'(o_s_addr), 32'(tbl[i].addr));
      $display("vec %0d in=%b grant=%b s_cyc=%b addr=%h", i, tbl[i].in, o_grant, o_s_cyc, o_s_addr);
      i_reset = 1'b1;
      step();
    end

    // Pipelined burst from m1: 4 reads, slave stalls the 2nd, acks one cycle after accept.
    drive_none();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 30'h0;
    issued = 0; accepts = 0; acks = 0;
    acc_prev = 1'b0; acc_addr = '0; stall_done = 1'b0; m0_ok = 1'b1;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      i_s_ack = acc_prev;
      i_s_data = 32'hA0 + 32'(acc_addr);
      #1;
      i_s_stall = (o_s_stb && accepts == 1 && !stall_done);
      #1;
      acc_now = o_s_stb && !i_s_stall;
      acc_addr_now = o_s_addr;
      if (acc_now) accepts++;
      if (o_s_stb && i_s_stall) stall_done = 1'b1;
      issue_now = i_m1_stb && !o_m1_stall;
      if (issue_now) sb.push_back(32'hA0 + 32'(i_m1_addr));
      if (o_m0_stall !== 1'b1) m0_ok = 1'b0;
      if (o_m1_ack) begin
        acks++;
        if (sb.size() == 0) chk("burst_unexpected_ack", 32'(acks), 32'h0);
        else chk("burst_data", o_m1_data, sb.pop_front());
        $display("burst ack %0d data=%h", acks, o_m1_data);
      end
      step();
      acc_prev = acc_now;
      acc_addr = acc_addr_now;
      if (issue_now) begin
        issued++;
        i_m1_addr = i_m1_addr + 30'd1;
        if (issued == 4) i_m1_stb = 1'b0;
      end
    end
    chk("burst_acks", 32'(acks), 32'd4);
    chk("burst_accepts", 32'(accepts), 32'd4);
    chk("burst_sb_empty", 32'(sb.size()), 32'd0);
    chk("burst_m0_stall", 32'(m0_ok), 32'd1);
    drive_none();
    step();
    step();

    // Non-owner isolation: m1 requests at addr 0x55 while m0 owns.
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m0_we = 1'b0; i_m0_addr = 30'h10;
    step();
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_we = 1'b1; i_m1_addr = 30'h55;
    for (int c = 0; c < 4; c++) begin
      i_s_ack = c[0];
      #1;
      chk("iso_grant", 32'(o_grant), 32'h1);
      chk("iso_addr", 32'(o_s_addr), 32'h10);
      chk("iso_we_data", {31'(o_s_data == 32'hDEADBEEF), o_s_we}, 32'h2);
      chk("iso_m1", 32'({o_m1_ack, o_m1_stall}), 32'h1);
      chk("iso_m0_ack", 32'(o_m0_ack), 32'(i_s_ack));
      $display("iso cycle %0d grant=%b addr=%h m1_ack=%b", c, o_grant, o_s_addr, o_m1_ack);
      step();
    end
    drive_none();
    step();
    step();

    // Asynchronous reset while m1 owns the bus.
    i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_m1_addr = 30'h33;
    step();
    i_s_ack = 1'b1;
    #1;
    chk("rst_pre_grant", 32'({o_grant, o_s_cyc, o_m1_ack}), 32'b1011);
    i_reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    $display("reset mid-transfer grant=%b s_cyc=%b", o_grant, o_s_cyc);
    i_reset = 1'b1;
    drive_none();
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks m0; m1 waits and must win after the abort.
    i_reset = 1'b0;
    #1;
    i_reset = 1'b1;
    i_m0_cyc = 1'b1; i_m0_stb = 1'b1; i_m1_cyc = 1'b1; i_m1_stb = 1'b1; i_s_stall = 1'b1;
    step();
    for (int c = 0; c < 11; c++) begin
      #1;
      chk($sformatf("to_err_c%0d", c), 32'({o_m0_err, o_m1_err}), (c == 8) ? 32'b10 : 32'b00);
      if (c == 8) chk("to_abort_scyc", 32'({o_s_cyc, o_m0_stall, o_m0_ack}), 32'b010);
      if (c == 9) chk("to_idle", 32'(o_grant), 32'h0);
      if (c == 10) chk("to_m1_next", 32'(o_grant), 32'h2);
      $display("timeout cycle %0d grant=%b m0_err=%b s_cyc=%b", c, o_grant, o_m0_err, o_s_cyc);
      step();
    end
    drive_none();
    step();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
